// File: rtl/cntr8_ns_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cntr8_ns_ctrl_if
//  Description : Bus between the 8-bit counter next-state controller and its
//                downstream output-logic stage (requests in, state/count out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cntr8_ns_ctrl_if;
  logic       load;    // load request
  logic       inc;     // increment request
  logic       dec;     // decrement request
  logic [7:0] cnt_in;  // next count produced by the output-logic stage
  logic [2:0] state;   // registered controller state
  logic [7:0] cnt;     // registered count (feedback operand)
  logic       wrap;    // one-cycle wrap-around pulse

  // Requester / output-logic side
  modport master (
    output load, inc, dec, cnt_in,
    input  state, cnt, wrap
  );

  // Controller side
  modport slave (
    input  load, inc, dec, cnt_in,
    output state, cnt, wrap
  );
endinterface
`default_nettype wire

// File: rtl/cntr8_ns_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cntr8_ns_ctrl
//  Description : Next-state controller for an 8-bit up/down counter. Chooses
//                the state by request priority (load > inc/dec > idle),
//                alternates A/B phases while counting, registers the count
//                fed back from the output-logic stage and flags wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module cntr8_ns_ctrl (
  input  logic           clk,
  input  logic           reset,
  cntr8_ns_ctrl_if.slave bus
);

  // State encodings seen on the state output
  localparam logic [2:0] IDLE_STATE = 3'b000;  // clears count
  localparam logic [2:0] LOAD_STATE = 3'b001;  // loads external data
  localparam logic [2:0] INC_STATE  = 3'b010;  // increment, phase A
  localparam logic [2:0] INC2_STATE = 3'b011;  // increment, phase B
  localparam logic [2:0] DEC_STATE  = 3'b100;  // decrement, phase A
  localparam logic [2:0] DEC2_STATE = 3'b101;  // decrement, phase B

  localparam logic [7:0] CNT_MAX  = 8'hFF;
  localparam logic [7:0] CNT_ZERO = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE = IDLE_STATE,
    S_LOAD = LOAD_STATE,
    S_INC  = INC_STATE,
    S_INC2 = INC2_STATE,
    S_DEC  = DEC_STATE,
    S_DEC2 = DEC2_STATE
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic       wrap_q;
  logic       wrap_d;
  logic       inc_phase;
  logic       dec_phase;

  // Next state by request priority; phase A/B toggle keeps the state moving
  // every cycle of a sustained count. Any state that is not the matching
  // phase A (including unused encodings) enters phase A.
  always_comb begin
    state_d = S_IDLE;
    if (bus.load) begin
      state_d = S_LOAD;
    end else if (bus.inc && !bus.dec) begin
      state_d = (state_q == S_INC) ? S_INC2 : S_INC;
    end else if (bus.dec && !bus.inc) begin
      state_d = (state_q == S_DEC) ? S_DEC2 : S_DEC;
    end
  end

  // Wrap detection: only a counting state that crosses the 8'hFF/8'h00
  // boundary in its own direction counts; loads and clears never wrap.
  always_comb begin
    inc_phase = (state_q == S_INC) || (state_q == S_INC2);
    dec_phase = (state_q == S_DEC) || (state_q == S_DEC2);
    wrap_d    = (inc_phase && (cnt_q == CNT_MAX)  && (bus.cnt_in == CNT_ZERO)) ||
                (dec_phase && (cnt_q == CNT_ZERO) && (bus.cnt_in == CNT_MAX));
  end

  // State register, updated every edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Count and wrap registers; count follows the stage with one cycle of lag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= CNT_ZERO;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= bus.cnt_in;
      wrap_q <= wrap_d;
    end
  end

  // All outputs come straight from registers
  assign bus.state = state_q;
  assign bus.cnt   = cnt_q;
  assign bus.wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_cntr8_ns_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cntr8_ns_ctrl
//  Description : Directed self-checking bench for cntr8_ns_ctrl. Models the
//                downstream output-logic stage (clear/load/+1/-1) with an
//                optional override of cnt_in.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cntr8_ns_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ext_data = 8'h00;
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'h00;
  logic [7:0] stage;
  int         checks = 0;
  int         errors = 0;

  cntr8_ns_ctrl_if bus();

  cntr8_ns_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Output-logic stage model: produces the next count for the current state
  always_comb begin
    case (bus.state)
      3'b001:         stage = ext_data;
      3'b010, 3'b011: stage = bus.cnt + 8'd1;
      3'b100, 3'b101: stage = bus.cnt - 8'd1;
      default:        stage = 8'h00;
    endcase
    bus.cnt_in = ovr_en ? ovr_val : stage;
  end

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.inc = 1'b0; bus.dec = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL reset_state got %b want 000", bus.state); end
    checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h want 00", bus.cnt); end
    checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", bus.wrap); end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.state !== 3'b000 || bus.cnt !== 8'h00) begin errors++; $display("FAIL post_reset_idle got %b/%h want 000/00", bus.state, bus.cnt); end
  endtask

  task automatic test_load();
    ext_data = 8'h5A; bus.load = 1'b1;
    tick();
    checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL load_state got %b want 001", bus.state); end
    bus.load = 1'b0; bus.inc = 1'b1;
    tick();
    checks++; if (bus.cnt !== 8'h5A) begin errors++; $display("FAIL load_cnt got %h want 5a", bus.cnt); end
    checks++; if (bus.state !== 3'b010) begin errors++; $display("FAIL load_then_inc_state got %b want 010", bus.state); end
  endtask

  task automatic test_inc_count();
    logic [2:0] es [3];
    logic [7:0] ec [3];
    es = '{3'b011, 3'b010, 3'b011};
    ec = '{8'h5B, 8'h5C, 8'h5D};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.state !== es[i] || bus.cnt !== ec[i] || bus.wrap !== 1'b0) begin
        errors++; $display("FAIL inc_count[%0d] got %b/%h/%b want %b/%h/0", i, bus.state, bus.cnt, bus.wrap, es[i], ec[i]);
      end
    end
    bus.inc = 1'b0;
    tick();
    checks++; if (bus.state !== 3'b000 || bus.cnt !== 8'h5E) begin errors++; $display("FAIL inc_count_end got %b/%h want 000/5e", bus.state, bus.cnt); end
    tick();
    checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL idle_clear got %h want 00", bus.cnt); end
  endtask

  // Load a start value, then count in one direction for four edges
  task automatic run_wrap(input string nm, input logic [7:0] start, input logic up,
                          input logic [2:0] pa, input logic [2:0] pb,
                          input logic [7:0] c0, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [7:0] c3, input logic [7:0] cend);
    logic [7:0] ec [4];
    logic       ew [4];
    ec = '{c0, c1, c2, c3};
    ew = '{1'b0, 1'b0, 1'b1, 1'b0};
    ext_data = start; bus.load = 1'b1;
    tick();
    bus.load = 1'b0; bus.inc = up; bus.dec = ~up;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.state !== ((i % 2 == 0) ? pa : pb) || bus.cnt !== ec[i] || bus.wrap !== ew[i]) begin
        errors++; $display("FAIL %s[%0d] got %b/%h/%b want %b/%h/%b", nm, i, bus.state, bus.cnt, bus.wrap,
                           (i % 2 == 0) ? pa : pb, ec[i], ew[i]);
      end
    end
    bus.inc = 1'b0; bus.dec = 1'b0;
    tick();
    checks++; if (bus.state !== 3'b000 || bus.cnt !== cend || bus.wrap !== 1'b0) begin errors++; $display("FAIL %s_end got %b/%h/%b want 000/%h/0", nm, bus.state, bus.cnt, bus.wrap, cend); end
  endtask

  task automatic test_inc_wrap();
    run_wrap("inc_wrap", 8'hFE, 1'b1, 3'b010, 3'b011, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02);
  endtask

  task automatic test_dec_wrap();
    run_wrap("dec_wrap", 8'h01, 1'b0, 3'b100, 3'b101, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFD);
  endtask

  task automatic test_load_no_wrap();
    ext_data = 8'hFE; bus.load = 1'b1;
    tick();
    bus.load = 1'b0; bus.inc = 1'b1;
    tick();
    ext_data = 8'h00; bus.load = 1'b1; bus.inc = 1'b0;
    tick();
    checks++; if (bus.state !== 3'b001 || bus.cnt !== 8'hFF) begin errors++; $display("FAIL load00_setup got %b/%h want 001/ff", bus.state, bus.cnt); end
    bus.load = 1'b0;
    tick();
    checks++; if (bus.cnt !== 8'h00 || bus.wrap !== 1'b0) begin errors++; $display("FAIL load00_wrap got %h/%b want 00/0", bus.cnt, bus.wrap); end
    ext_data = 8'hFF; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    checks++; if (bus.cnt !== 8'h00 || bus.wrap !== 1'b0) begin errors++; $display("FAIL idle_clear_wrap got %h/%b want 00/0", bus.cnt, bus.wrap); end
  endtask

  task automatic test_priority();
    logic       ti [6];
    logic       td [6];
    logic [2:0] es [6];
    logic [7:0] ec [6];
    logic       ew [6];
    ext_data = 8'h33; bus.load = 1'b1; bus.inc = 1'b1; bus.dec = 1'b1;
    tick();
    checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL prio_load got %b want 001", bus.state); end
    bus.load = 1'b0;
    tick();
    checks++; if (bus.state !== 3'b000 || bus.cnt !== 8'h33 || bus.wrap !== 1'b0) begin errors++; $display("FAIL prio_both got %b/%h/%b want 000/33/0", bus.state, bus.cnt, bus.wrap); end
    tick();
    checks++; if (bus.state !== 3'b000 || bus.cnt !== 8'h00 || bus.wrap !== 1'b0) begin errors++; $display("FAIL prio_both_clear got %b/%h/%b want 000/00/0", bus.state, bus.cnt, bus.wrap); end
    // Direction changes mid-count, then release
    ti = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    td = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    es = '{3'b010, 3'b100, 3'b101, 3'b010, 3'b000, 3'b000};
    ec = '{8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h00};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      bus.inc = ti[i]; bus.dec = td[i];
      tick();
      checks++;
      if (bus.state !== es[i] || bus.cnt !== ec[i] || bus.wrap !== ew[i]) begin
        errors++; $display("FAIL dir_change[%0d] got %b/%h/%b want %b/%h/%b", i, bus.state, bus.cnt, bus.wrap, es[i], ec[i], ew[i]);
      end
    end
  endtask

  task automatic test_wrap_needs_cnt_in();
    ext_data = 8'hFE; bus.load = 1'b1;
    tick();
    bus.load = 1'b0; bus.inc = 1'b1;
    tick();
    tick();
    ovr_en = 1'b1; ovr_val = 8'h10;
    tick();
    checks++; if (bus.cnt !== 8'h10 || bus.wrap !== 1'b0) begin errors++; $display("FAIL inc_ff_no_zero got %h/%b want 10/0", bus.cnt, bus.wrap); end
    ovr_en = 1'b0; bus.inc = 1'b0; bus.dec = 1'b1;
    tick();
    checks++; if (bus.state !== 3'b100 || bus.cnt !== 8'h11) begin errors++; $display("FAIL inc_to_dec got %b/%h want 100/11", bus.state, bus.cnt); end
    ovr_en = 1'b1; ovr_val = 8'hFF;
    tick();
    checks++; if (bus.cnt !== 8'hFF || bus.wrap !== 1'b0) begin errors++; $display("FAIL dec_nonzero_no_wrap got %h/%b want ff/0", bus.cnt, bus.wrap); end
    ovr_en = 1'b0; bus.dec = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    ext_data = 8'hFE; bus.load = 1'b1;
    tick();
    bus.load = 1'b0; bus.inc = 1'b1;
    tick();
    tick();
    checks++; if (bus.state !== 3'b011 || bus.cnt !== 8'hFF) begin errors++; $display("FAIL ar_setup got %b/%h want 011/ff", bus.state, bus.cnt); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.state !== 3'b000 || bus.cnt !== 8'h00 || bus.wrap !== 1'b0) begin errors++; $display("FAIL ar_mid_count got %b/%h/%b want 000/00/0", bus.state, bus.cnt, bus.wrap); end
    tick();
    checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL ar_held got %b want 000", bus.state); end
    reset = 1'b0;
    tick();
    checks++; if (bus.state !== 3'b010 || bus.cnt !== 8'h00) begin errors++; $display("FAIL ar_resume got %b/%h want 010/00", bus.state, bus.cnt); end
    tick();
    checks++; if (bus.state !== 3'b011 || bus.cnt !== 8'h01) begin errors++; $display("FAIL ar_resume2 got %b/%h want 011/01", bus.state, bus.cnt); end
    // Reset while the wrap pulse is high
    bus.inc = 1'b0; ext_data = 8'hFF; bus.load = 1'b1;
    tick();
    bus.load = 1'b0; bus.inc = 1'b1;
    tick();
    tick();
    checks++; if (bus.wrap !== 1'b1) begin errors++; $display("FAIL ar_wrap_setup got %b want 1", bus.wrap); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.wrap !== 1'b0 || bus.state !== 3'b000) begin errors++; $display("FAIL ar_wrap_clear got %b/%b want 0/000", bus.wrap, bus.state); end
    bus.inc = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "time limit");
  end

  initial begin
    ext_data = 8'h00;
    test_reset();
    test_load();
    test_inc_count();
    test_inc_wrap();
    test_dec_wrap();
    test_load_no_wrap();
    test_priority();
    test_wrap_needs_cnt_in();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cntr8_ns_ctrl.md
CNTR8_NS_CTRL -- requirements
Module: cntr8_ns_ctrl

Interface
REQ-001 Parameter IDLE_STATE, 3'b000, clears count.
REQ-002 Parameter LOAD_STATE, 3'b001, loads external data.
REQ-003 Parameter INC_STATE, 3'b010, increment, phase A.
REQ-004 Parameter INC2_STATE, 3'b011, increment, phase B.
REQ-005 Parameter DEC_STATE, 3'b100, decrement, phase A.
REQ-006 Parameter DEC2_STATE, 3'b101, decrement, phase B.
REQ-007 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-008 Port reset  input  1  asynchronous, active-high reset.
REQ-009 Port load  input  1  load request.
REQ-010 Port inc  input  1  increment request.
REQ-011 Port dec  input  1  decrement request.
REQ-012 Port cnt_in  input  8  next count value produced by the downstream output-logic stage for the current state.
REQ-013 Port state  output  3  registered state; drives the downstream output-logic stage.
REQ-014 Port cnt  output  8  registered count; the feedback operand for the downstream incrementer/decrementer.
REQ-015 Port wrap  output  1  one-cycle pulse on counter wrap-around.

Function
REQ-016 The next state SHALL be chosen by request priority: load > inc/dec > none.
REQ-017 When load=1, the next state SHALL be LOAD_STATE from any state, regardless of inc and dec.
REQ-018 When load=0, inc=1 and dec=0:
- INC_STATE SHALL go to INC2_STATE.
- INC2_STATE SHALL go to INC_STATE.
- Any other state SHALL go to INC_STATE.
REQ-019 When load=0, dec=1 and inc=0:
- DEC_STATE SHALL go to DEC2_STATE.
- DEC2_STATE SHALL go to DEC_STATE.
- Any other state SHALL go to DEC_STATE.
REQ-020 When load=0 and inc=dec (both 0 or both 1), the next state SHALL be IDLE_STATE.
REQ-021 The state SHALL toggle between phases A and B on every cycle of a sustained inc or dec, so that state changes every cycle while counting.
REQ-022 Encodings 3'b110 and 3'b111 SHALL never be produced; if present, the next state SHALL follow REQ-017..020, treating them as "any other state".
REQ-023 The state register SHALL update on every rising clk edge; there is no enable.
REQ-024 cnt SHALL capture cnt_in on every rising clk edge, giving one cycle of latency from state to cnt.
REQ-025 All count arithmetic is modulo 256; wrap-around is permitted and SHALL NOT saturate.
REQ-026 wrap SHALL be registered and asserted for exactly one cycle after an edge where either:
- state ∈ {INC_STATE, INC2_STATE} and cnt=8'hFF and cnt_in=8'h00, or
- state ∈ {DEC_STATE, DEC2_STATE} and cnt=8'h00 and cnt_in=8'hFF.
REQ-027 wrap SHALL be 0 in the IDLE_STATE and LOAD_STATE cases, including a load of 8'h00 while cnt=8'hFF.
REQ-028 Inputs load, inc and dec SHALL be sampled only at the rising clk edge; no combinational path SHALL exist from any input to any output.

Reset
REQ-029 While reset=1, the block SHALL drive state=IDLE_STATE, cnt=8'h00 and wrap=0, immediately and independently of clk.
REQ-030 Assertion of reset mid-count SHALL abandon the sequence.
REQ-031 After reset deasserts, the first rising edge SHALL apply REQ-016..020 starting from IDLE_STATE.
REQ-032 No output SHALL be X after reset.

Verification
REQ-033 Reset, then load=1 with the stage supplying cnt_in=8'h5A -> state=001 after edge 1; cnt=8'h5A after edge 2.
REQ-034 From cnt=8'h5A, hold inc=1 for 4 edges -> state sequence 010,011,010,011; cnt reaches 8'h5B..8'h5E with one-cycle lag; wrap stays 0.
REQ-035 Load 8'hFE, then inc=1 -> cnt goes FE, FF, 00; wrap=1 for exactly the cycle after the FF->00 capture.
REQ-036 Load 8'h01, then dec=1 -> cnt goes 01, 00, FF; wrap pulses once; the state alternates 100/101.
REQ-037 Apply load=1 with inc=1 and dec=1 -> LOAD wins. Then inc=1 with dec=1 -> IDLE, cnt=00, wrap=0.
REQ-038 Assert reset asynchronously between edges during INC2_STATE -> state=000, cnt=00 and wrap=0 before the next edge; counting resumes from IDLE after release.
